// File: rtl/l2_word_responder_if.sv
// Request/response bundle between the data cache and its L2 backing store.
// Shared memory operation type lives in l2_pkg alongside the interface.
package l2_pkg;
  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    STORE = 2'b01,
    NOP   = 2'b10,
    FLUSH = 2'b11
  } memory_operation_e;
endpackage

interface l2_word_responder_if #(
  parameter int XLEN = 32
);
  import l2_pkg::*;

  logic [XLEN-1:0]   l2_req_address;
  memory_operation_e l2_req_type;
  logic              l2_req_valid;
  logic [XLEN-1:0]   l2_word_to_store;
  logic [XLEN-1:0]   l2_fetched_word;
  logic              l2_req_fulfilled;

  modport master (
    output l2_req_address,
    output l2_req_type,
    output l2_req_valid,
    output l2_word_to_store,
    input  l2_fetched_word,
    input  l2_req_fulfilled
  );

  modport slave (
    input  l2_req_address,
    input  l2_req_type,
    input  l2_req_valid,
    input  l2_word_to_store,
    output l2_fetched_word,
    output l2_req_fulfilled
  );
endinterface

// File: rtl/l2_word_responder.sv
// Word-granular fixed-latency L2 stand-in / scratch memory below dcache.
// Optional L2_RESPONDER_PROTOCOL_CHECK_EN adds a sticky protocol_error output.
module l2_word_responder
  import l2_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int MEM_WORDS      = 1024,
  parameter int ACCESS_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  l2_word_responder_if.slave bus
`ifdef L2_RESPONDER_PROTOCOL_CHECK_EN
  ,
  output logic protocol_error
`endif
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (ACCESS_LATENCY > 1) ?
                      $clog2(ACCESS_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     idx_q;
  memory_operation_e type_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   fetched_q;
  logic [XLEN-1:0]   mem [MEM_WORDS];

  logic            accept;
  logic            rd_en;
  logic            is_load;
  logic [AW-1:0]   rd_idx;
  logic [AW-1:0]   req_idx;

  assign req_idx = bus.l2_req_address[2 +: AW];
  assign accept  = (state_q == IDLE) && bus.l2_req_valid;

  // With a latency of one the read happens on the accepting edge,
  // so the live request fields feed the read port instead of the latches.
  assign is_load = (state_q == IDLE) ?
                   (bus.l2_req_type == LOAD) :
                   (type_q == LOAD);
  assign rd_idx  = (state_q == IDLE) ? req_idx : idx_q;
  assign rd_en   = (state_d == DONE) && (state_q != DONE) && is_load;

  always_comb begin
    state_d              = state_q;
    cnt_d                = cnt_q;
    bus.l2_req_fulfilled = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.l2_req_valid) begin
          cnt_d   = CW'(ACCESS_LATENCY - 1);
          state_d = (ACCESS_LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        bus.l2_req_fulfilled = 1'b1;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      type_q    <= LOAD;
      wdata_q   <= '0;
      fetched_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= req_idx;
        type_q  <= bus.l2_req_type;
        wdata_q <= bus.l2_word_to_store;
      end
      if (rd_en) fetched_q <= mem[rd_idx];
    end
  end

  // Storage is deliberately not reset; a reset mid-request drops the store.
  always_ff @(posedge clk) begin
    if (!reset && state_q == DONE && type_q == STORE)
      mem[idx_q] <= wdata_q;
  end

  assign bus.l2_fetched_word = fetched_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.l2_req_address[XLEN-1:AW+2],
                              bus.l2_req_address[1:0]};

`ifdef L2_RESPONDER_PROTOCOL_CHECK_EN
  logic [XLEN-1:0] addr_q;
  logic            in_flight;
  logic            changed;

  assign in_flight = (state_q == BUSY) || (state_q == DONE);
  assign changed   = !bus.l2_req_valid ||
                     (bus.l2_req_address != addr_q) ||
                     (bus.l2_req_type != type_q) ||
                     (bus.l2_word_to_store != wdata_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q         <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (accept) addr_q <= bus.l2_req_address;
      if (in_flight && changed) protocol_error <= 1'b1;
    end
  end
`endif

endmodule
